// File: rtl/sdram_arbiter.sv
// Two-port front end for the 8-phase SDRAM controller: tracks the controller phase,
// grants port A (priority) or B (starvation-protected) once per memory cycle.
module sdram_arbiter #(
    parameter int unsigned STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        init,
    input  logic        clkref,

    input  logic        a_req,
    input  logic        a_we,
    input  logic [24:0] a_addr,
    input  logic [15:0] a_din,
    input  logic [1:0]  a_ds,
    output logic        a_ack,
    output logic [15:0] a_dout,

    input  logic        b_req,
    input  logic        b_we,
    input  logic [24:0] b_addr,
    input  logic [15:0] b_din,
    input  logic [1:0]  b_ds,
    output logic        b_ack,
    output logic [15:0] b_dout,

    output logic [24:0] sd_addr,
    output logic [15:0] sd_din,
    output logic [1:0]  sd_ds,
    output logic        sd_oe,
    output logic        sd_we,
    input  logic [15:0] sd_dout
);

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_A,
        GNT_B
    } grant_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    grant_t      grant, grant_nxt;
    logic [2:0]  ph;
    logic        locked;
    logic [3:0]  starve, starve_nxt;
    logic        ph_adv;
    logic        cyc_edge;
    logic        a_elig, b_elig;

    always_comb begin
        ph_adv     = ((ph == 3'd7) && !clkref) || ((ph == 3'd0) && clkref) ||
                     ((ph != 3'd0) && (ph != 3'd7));
        // Phase 6 always advances, so this is the 6->7 edge once aligned.
        cyc_edge   = locked && (ph == 3'd6);
        a_elig     = a_req && (grant != GNT_A);
        b_elig     = b_req && (grant != GNT_B);
        grant_nxt  = grant;
        starve_nxt = starve;
        if (cyc_edge) begin
            if (b_elig && (starve == STARVE_LIM))
                grant_nxt = GNT_B;
            else if (a_elig)
                grant_nxt = GNT_A;
            else if (b_elig)
                grant_nxt = GNT_B;
            else
                grant_nxt = GNT_NONE;

            if (grant_nxt == GNT_B)
                starve_nxt = '0;
            else if ((grant_nxt == GNT_A) && b_req && (starve != STARVE_LIM))
                starve_nxt = starve + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (init) begin
            ph      <= '0;
            locked  <= 1'b0;
            grant   <= GNT_NONE;
            starve  <= '0;
            a_ack   <= 1'b0;
            b_ack   <= 1'b0;
            a_dout  <= '0;
            b_dout  <= '0;
            sd_addr <= '0;
            sd_din  <= '0;
            sd_ds   <= '0;
            sd_oe   <= 1'b0;
            sd_we   <= 1'b0;
        end else begin
            ph     <= ph + {2'b00, ph_adv};
            if ((ph == 3'd0) && clkref)
                locked <= 1'b1;
            grant  <= grant_nxt;
            starve <= starve_nxt;
            a_ack  <= 1'b0;
            b_ack  <= 1'b0;
            if (cyc_edge) begin
                // sd_oe still reflects the access that is completing here.
                case (grant)
                    GNT_A: begin
                        a_ack <= 1'b1;
                        if (sd_oe)
                            a_dout <= sd_dout;
                    end
                    GNT_B: begin
                        b_ack <= 1'b1;
                        if (sd_oe)
                            b_dout <= sd_dout;
                    end
                    default: ;
                endcase

                case (grant_nxt)
                    GNT_A: begin
                        sd_addr <= a_addr;
                        sd_din  <= a_din;
                        sd_ds   <= a_ds;
                        sd_we   <= a_we;
                        sd_oe   <= !a_we;
                    end
                    GNT_B: begin
                        sd_addr <= b_addr;
                        sd_din  <= b_din;
                        sd_ds   <= b_ds;
                        sd_we   <= b_we;
                        sd_oe   <= !b_we;
                    end
                    default: begin
                        sd_we <= 1'b0;
                        sd_oe <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule
